// File: rtl/buf_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : buf_rr_arbiter
//  Description : Round-robin arbiter sharing one registered output word stage
//                between NUM_REQ valid/ready requesters. The winner's word is
//                captured together with its source index; one word per cycle
//                is sustained while downstream is ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module buf_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int SRC_W   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready
);

    logic [SRC_W-1:0]  r_rr_ptr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SRC_W-1:0]  r_out_src;

    logic [DATA_W-1:0] w_words [NUM_REQ];
    logic              w_found;
    logic [SRC_W-1:0]  w_win;
    logic              w_can_accept;
    logic              w_accept;

    // Unpack the flattened request bus into one word per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_words[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // Search from the round-robin pointer upward (wrapping) for the first
    // valid requester. NUM_REQ is a power of two, so SRC_W-bit addition wraps.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[r_rr_ptr + SRC_W'(k)]) begin
                w_found = 1'b1;
                w_win   = r_rr_ptr + SRC_W'(k);
            end
        end
    end

    // The register can take a new word when empty or when it drains this cycle.
    assign w_can_accept = !r_out_valid || out_ready;
    assign w_accept     = w_found && w_can_accept && !reset;
    assign req_ready    = w_accept ? (NUM_REQ'(1) << w_win) : '0;

    // Output register and pointer: accept (possibly replacing a draining
    // word), plain drain, or hold on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_words[w_win];
            r_out_src   <= w_win;
            r_rr_ptr    <= w_win + SRC_W'(1);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_buf_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_buf_rr_arbiter
//  Description : Self-checking bench for buf_rr_arbiter: vector table,
//                directed corner sequences and randomized reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_buf_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int SRC_W   = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;

    int n_checks = 0;
    int n_errors = 0;

    buf_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic        o;
        logic [3:0]  er;
        logic        eov;
        logic [1:0]  es;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [13];

    // Apply inputs just after a rising edge; sample one step later.
    task automatic drive(input logic r, input logic [3:0] v, input logic o,
                         input logic [NUM_REQ*DATA_W-1:0] d);
        @(posedge clk);
        #1;
        reset     = r;
        req_valid = v;
        out_ready = o;
        req_data  = d;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model state
    bit          m_ov;
    bit [31:0]   m_data;
    int          m_src;
    int          m_ptr;

    function automatic int model_win(input logic [3:0] v);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        return -1;
    endfunction

    initial begin
        logic [NUM_REQ*DATA_W-1:0] td;
        logic [NUM_REQ*DATA_W-1:0] d;
        td = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};

        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
        tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h0};
        tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h1000_0000};
        tbl[3]  = '{1'b0, 4'b0101, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h1000_0001};
        tbl[4]  = '{1'b0, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd1, 32'h1000_0001};
        tbl[5]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd2, 32'h1000_0002};
        tbl[6]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h1000_0000};
        tbl[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h1000_0000};
        tbl[8]  = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0, 2'd0, 32'h1000_0000};
        tbl[9]  = '{1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3, 32'h1000_0003};
        tbl[10] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h1000_0000};
        tbl[11] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0, 32'h0};
        tbl[12] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h1000_0001};

        reset = 1'b1; req_valid = '0; out_ready = 1'b0; req_data = '0;

        // ---------------- vector table ----------------
        drive(1'b1, 4'b0000, 1'b0, td);
        drive(1'b1, 4'b0000, 1'b0, td);
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].o, td);
            chk($sformatf("tbl%0d req_ready", i), 32'(req_ready), 32'(tbl[i].er));
            chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
            chk($sformatf("tbl%0d out_src", i), 32'(out_src), 32'(tbl[i].es));
            chk($sformatf("tbl%0d out_data", i), out_data, tbl[i].ed);
        end

        // ---------------- single-requester stream ----------------
        drive(1'b1, 4'b0000, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            d = '0;
            d[2*DATA_W +: DATA_W] = 32'hA000_0001 + 32'(i);
            drive(1'b0, (i < 4) ? 4'b0100 : 4'b0000, 1'b1, d);
            if (i < 4) chk("stream req_ready", 32'(req_ready), 32'h4);
            if (i > 0) begin
                chk("stream out_data", out_data, 32'hA000_0000 + 32'(i));
                chk("stream out_src", 32'(out_src), 32'd2);
            end
        end

        // ---------------- fairness + reset mid-stream ----------------
        drive(1'b1, 4'b0000, 1'b0, td);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 4'b1111, 1'b1, td);
            chk("fair req_ready", 32'(req_ready), 32'(1 << (k % 4)));
            if (k > 0) chk("fair out_src", 32'(out_src), 32'((k - 1) % 4));
        end
        drive(1'b1, 4'b1111, 1'b1, td);
        chk("midrst req_ready", 32'(req_ready), 32'h0);
        drive(1'b0, 4'b1111, 1'b1, td);
        chk("midrst out_valid", 32'(out_valid), 32'h0);
        chk("midrst grant0", 32'(req_ready), 32'h1);
        drive(1'b0, 4'b1111, 1'b1, td);
        chk("midrst resume src", 32'(out_src), 32'h0);

        // ---------------- backpressure ----------------
        drive(1'b1, 4'b0000, 1'b0, '0);
        d = td; d[1*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        drive(1'b0, 4'b0010, 1'b1, d);
        chk("bp fill ready", 32'(req_ready), 32'h2);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'b1111, 1'b0, td);
            chk("bp stall ready", 32'(req_ready), 32'h0);
            chk("bp stall data", out_data, 32'hDEAD_BEEF);
            chk("bp stall src", 32'(out_src), 32'd1);
            chk("bp stall valid", 32'(out_valid), 32'h1);
        end
        drive(1'b0, 4'b1111, 1'b1, td);
        chk("bp release grant", 32'(req_ready), 32'h4);

        // ---------------- drain vs. refill ----------------
        drive(1'b0, 4'b0000, 1'b1, td);
        chk("drain pre valid", 32'(out_valid), 32'h1);
        chk("drain pre src", 32'(out_src), 32'd2);
        drive(1'b0, 4'b0000, 1'b1, td);
        chk("drain valid", 32'(out_valid), 32'h0);
        d = td; d[2*DATA_W +: DATA_W] = 32'h2222_2222;
        drive(1'b0, 4'b0100, 1'b1, d);
        chk("refill load ready", 32'(req_ready), 32'h4);
        d = td; d[3*DATA_W +: DATA_W] = 32'h1234_5678;
        drive(1'b0, 4'b1000, 1'b1, d);
        chk("refill ready", 32'(req_ready), 32'h8);
        chk("refill old data", out_data, 32'h2222_2222);
        drive(1'b0, 4'b1111, 1'b0, td);
        chk("refill valid", 32'(out_valid), 32'h1);
        chk("refill data", out_data, 32'h1234_5678);
        chk("refill src", 32'(out_src), 32'd3);
        drive(1'b0, 4'b1111, 1'b1, td);
        chk("refill wrap grant", 32'(req_ready), 32'h1);

        // ---------------- randomized vs. model ----------------
        drive(1'b1, 4'b0000, 1'b0, '0);
        m_ov = 0; m_data = '0; m_src = 0; m_ptr = 0;
        for (int c = 0; c < 500; c++) begin
            logic       r;
            logic [3:0] v;
            logic       o;
            int         w;
            logic [3:0] er;
            r = ($urandom_range(0, 39) == 0);
            v = 4'($urandom);
            o = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_REQ; i++) d[i*DATA_W +: DATA_W] = $urandom;
            drive(r, v, o, d);
            w  = model_win(v);
            er = 4'b0000;
            if (!r && (!m_ov || o) && w >= 0) er = 4'(1 << w);
            chk("rnd req_ready", 32'(req_ready), 32'(er));
            chk("rnd out_valid", 32'(out_valid), 32'(m_ov));
            chk("rnd out_src", 32'(out_src), 32'(m_src));
            chk("rnd out_data", out_data, m_data);
            if (r) begin
                m_ov = 0; m_data = '0; m_src = 0; m_ptr = 0;
            end else if (er != 0) begin
                m_ov = 1; m_data = d[w*DATA_W +: DATA_W]; m_src = w;
                m_ptr = (w + 1) % NUM_REQ;
            end else if (o) begin
                m_ov = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/buf_rr_arbiter.md
Name: buf_rr_arbiter

Overview:
- Round-robin arbiter sharing one 32-bit registered buffer stage between NUM_REQ requesters (e.g. operand fetch ports feeding BitFusion fusion units).
- Each requester offers a word with a valid/ready handshake. The winner's word is captured into a single output register and presented downstream with its source index.
- Sustains one word per cycle when downstream is ready; fair rotation among active requesters.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..8.
- DATA_W, 32, word width.
- SRC_W, 2, index width; must equal log2(NUM_REQ).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i = requester i offers a word.
- req_data  input  NUM_REQ*DATA_W  flattened words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot or zero; bit i = requester i's word accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_W  registered word.
- out_src  output  SRC_W  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset state: out_valid=0, out_data=0, out_src=0, rr_ptr=0. req_ready=0 while reset is high, regardless of other inputs.
- Space condition: can_accept = !out_valid | out_ready.
- Grant (combinational): among set req_valid bits, search indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first found wins.
  - req_ready[win] = can_accept & !reset; all other bits are 0.
  - No valid requester: req_ready=0.
- Handshake: a transfer on requester i occurs when req_valid[i] & req_ready[i].
  - Requesters hold valid and data stable until accepted. The arbiter tolerates grant changes while not accepting, because nothing is consumed then.
- Accept (at edge): out_data <= winner's word, out_src <= win, out_valid <= 1, rr_ptr <= (win+1) mod NUM_REQ.
- Latency: accepted word is visible on out_* the cycle after acceptance.
- Drain without accept (out_valid & out_ready, no requester valid): out_valid <= 0. out_data and out_src hold their last value.
- Simultaneous drain and accept (out_valid & out_ready & any req_valid): new word replaces the old in the same edge and out_valid stays 1. Gives full throughput of one word per cycle.
- Stall (out_valid & !out_ready): req_ready=0; out_data, out_src, out_valid and rr_ptr hold.
- rr_ptr changes only on an accept. Wrap-around: win=NUM_REQ-1 gives rr_ptr=0.
- Reset mid-operation: a pending output word is discarded (out_valid=0 next cycle). No requester sees ready during the reset cycle, so no word is lost silently.
- No combinational path from req_data to out_data; the only combinational outputs are req_ready from req_valid, out_ready and rr_ptr.

Test Plan:
- Reset check: assert reset with all req_valid=1 and out_ready=1 -> req_ready=0 and out_valid=0 during reset. After release, first grant goes to requester 0.
- Single-requester stream: req_valid=4'b0100, data 0xA0000001..0xA0000004, out_ready=1 -> four consecutive transfers. out_data matches in order one cycle later; out_src=2; req_ready=4'b0100 every cycle.
- Fairness: all four valid continuously, data 0x1000_000i per requester, out_ready=1 -> out_src sequence 0,1,2,3,0,1,2,3 and req_ready one-hot rotating every cycle.
- Backpressure: fill output with 0xDEADBEEF from requester 1, then hold out_ready=0 for 5 cycles with req_valid=4'b1111 -> out_data stays 0xDEADBEEF, req_ready=0 and rr_ptr unchanged. On out_ready=1, requester 2 is granted next.
- Drain vs. refill: out_valid=1, out_ready=1, no req_valid -> out_valid=0 next cycle. Repeat with req_valid[3]=1 and data 0x12345678 -> out_valid stays 1, out_data=0x12345678, out_src=3, rr_ptr wraps to 0.
- Reset mid-stream: during the fairness stream, pulse reset one cycle -> out_valid=0 the next cycle and rr_ptr=0. The stream resumes with out_src=0.
